// File: rtl/width_16to8.sv
// width_16to8: splits a 16-bit valid/ready word stream into a byte stream, two bytes per word
module width_16to8 #(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_in,
  input  logic [15:0] data_in,
  output logic        ready_in,
  output logic        valid_out,
  output logic [7:0]  data_out,
  input  logic        ready_out
);
  logic [15:0] word_buf;
  logic [1:0]  cnt;
  logic [7:0]  first_byte;
  logic [7:0]  second_byte;
  logic        accept;
  logic        xfer;
  // Output side decodes only registers; ready_in alone sees ready_out so a word can load as the last byte leaves
  always_comb begin
    first_byte  = MSB_FIRST ? word_buf[15:8] : word_buf[7:0];
    second_byte = MSB_FIRST ? word_buf[7:0]  : word_buf[15:8];
    valid_out   = cnt != 2'd0;
    data_out    = (cnt == 2'd2) ? first_byte : second_byte;
    ready_in    = (cnt == 2'd0) || (cnt == 2'd1 && ready_out);
    accept      = valid_in && ready_in;
    xfer        = valid_out && ready_out;
  end
  // Acceptance reloads the word and wins over a transfer; otherwise a transfer counts down one byte
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      word_buf <= '0;
      cnt      <= 2'd0;
    end else if (accept) begin
      word_buf <= data_in;
      cnt      <= 2'd2;
    end else if (xfer) begin
      cnt      <= cnt - 2'd1;
    end
endmodule

// File: tb/tb_width_16to8.sv
// tb_width_16to8: directed and scoreboard checks of the 16-to-8 splitter in both byte orders
module tb_width_16to8;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_in;
  logic [15:0] data_in;
  logic        ready_out;
  logic        ready_in, valid_out;
  logic [7:0]  data_out;
  logic        ready_in_l, valid_out_l;
  logic [7:0]  data_out_l;
  int          n_cmp = 0;
  int          n_err = 0;
  logic [7:0]  qm[$];
  logic [7:0]  ql[$];

  width_16to8 #(.MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .data_in(data_in), .ready_in(ready_in),
    .valid_out(valid_out), .data_out(data_out), .ready_out(ready_out)
  );

  width_16to8 #(.MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .data_in(data_in), .ready_in(ready_in_l),
    .valid_out(valid_out_l), .data_out(data_out_l), .ready_out(ready_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic outs(input string tag, input logic v, input logic [7:0] d, input logic [7:0] dl, input logic r);
    chk({tag, "_valid"}, valid_out, v);
    chk({tag, "_data"}, data_out, d);
    chk({tag, "_ready_in"}, ready_in, r);
    chk({tag, "_valid_l"}, valid_out_l, v);
    chk({tag, "_data_l"}, data_out_l, dl);
  endtask

  initial begin
    logic acc, xf;
    int   sent, cyc;
    logic [15:0] w;
    rst_n = 1'b0; valid_in = 1'b0; data_in = '0; ready_out = 1'b0;
    #1;
    outs("reset", 1'b0, 8'h00, 8'h00, 1'b1);
    tick; tick;
    rst_n = 1'b1;
    // single word
    ready_out = 1'b1; valid_in = 1'b1; data_in = 16'hA55A;
    tick; valid_in = 1'b0;
    outs("single_b0", 1'b1, 8'hA5, 8'h5A, 1'b0);
    tick;
    outs("single_b1", 1'b1, 8'h5A, 8'hA5, 1'b1);
    tick;
    outs("single_idle", 1'b0, 8'h5A, 8'hA5, 1'b1);
    tick;
    outs("single_idle2", 1'b0, 8'h5A, 8'hA5, 1'b1);
    // back-to-back words
    valid_in = 1'b1; data_in = 16'h1234;
    #1; chk("b2b_ready0", ready_in, 1'b1);
    tick; data_in = 16'h5678;
    outs("b2b_12", 1'b1, 8'h12, 8'h34, 1'b0);
    tick;
    outs("b2b_34", 1'b1, 8'h34, 8'h12, 1'b1);
    tick; data_in = 16'h9ABC;
    outs("b2b_56", 1'b1, 8'h56, 8'h78, 1'b0);
    tick;
    outs("b2b_78", 1'b1, 8'h78, 8'h56, 1'b1);
    tick; valid_in = 1'b0;
    outs("b2b_9a", 1'b1, 8'h9A, 8'hBC, 1'b0);
    tick;
    outs("b2b_bc", 1'b1, 8'hBC, 8'h9A, 1'b1);
    tick;
    outs("b2b_idle", 1'b0, 8'hBC, 8'h9A, 1'b1);
    // backpressure on first byte
    valid_in = 1'b1; data_in = 16'hBEEF;
    tick; valid_in = 1'b0; ready_out = 1'b0;
    outs("bp_first", 1'b1, 8'hBE, 8'hEF, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick;
      outs("bp_hold", 1'b1, 8'hBE, 8'hEF, 1'b0);
    end
    ready_out = 1'b1;
    #1; chk("bp_release_ready_in", ready_in, 1'b0);
    tick;
    outs("bp_second", 1'b1, 8'hEF, 8'hBE, 1'b1);
    tick;
    outs("bp_idle", 1'b0, 8'hEF, 8'hBE, 1'b1);
    // stall on second byte with a waiting word
    valid_in = 1'b1; data_in = 16'h1122;
    tick; valid_in = 1'b0;
    outs("st_11", 1'b1, 8'h11, 8'h22, 1'b0);
    tick;
    ready_out = 1'b0; valid_in = 1'b1; data_in = 16'hC0DE;
    #1;
    outs("st_stall", 1'b1, 8'h22, 8'h11, 1'b0);
    tick;
    outs("st_hold", 1'b1, 8'h22, 8'h11, 1'b0);
    ready_out = 1'b1;
    #1; chk("st_ready_in_rise", ready_in, 1'b1);
    tick; valid_in = 1'b0;
    outs("st_c0", 1'b1, 8'hC0, 8'hDE, 1'b0);
    tick;
    outs("st_de", 1'b1, 8'hDE, 8'hC0, 1'b1);
    tick;
    outs("st_idle", 1'b0, 8'hDE, 8'hC0, 1'b1);
    // reset mid-word on the second byte
    valid_in = 1'b1; data_in = 16'h3344;
    tick; valid_in = 1'b0;
    tick;
    outs("rm_44", 1'b1, 8'h44, 8'h33, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    outs("rm_async", 1'b0, 8'h00, 8'h00, 1'b1);
    tick; tick;
    rst_n = 1'b1;
    tick;
    outs("rm_after", 1'b0, 8'h00, 8'h00, 1'b1);
    tick;
    outs("rm_after2", 1'b0, 8'h00, 8'h00, 1'b1);
    // random valid/ready with scoreboard
    sent = 0; cyc = 0;
    while ((sent < 10000 || qm.size() != 0) && cyc < 90000) begin
      if (!valid_in && sent < 10000 && $urandom_range(3) != 0) begin
        valid_in = 1'b1; data_in = 16'($urandom);
      end
      ready_out = ($urandom_range(3) != 0);
      #1;
      acc = valid_in && ready_in;
      xf  = valid_out && ready_out;
      if (xf) begin
        if (qm.size() == 0) chk("rnd_spurious", 32'd1, 32'd0);
        else begin
          chk("rnd_msb", data_out, qm.pop_front());
          chk("rnd_lsb", data_out_l, ql.pop_front());
        end
      end
      if (acc) begin
        w = data_in;
        qm.push_back(w[15:8]); qm.push_back(w[7:0]);
        ql.push_back(w[7:0]);  ql.push_back(w[15:8]);
        sent++;
      end
      tick;
      if (acc) valid_in = 1'b0;
      cyc++;
    end
    chk("rnd_words_sent", sent, 10000);
    chk("rnd_queue_drained", qm.size(), 0);
    chk("rnd_end_valid", valid_out, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
